gmii_tx_framer: RTL and testbench

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

---
 rtl/gmii_tx_framer_if.sv | 24 ++
 rtl/gmii_tx_framer.sv | 189 ++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_framer_if.sv
// Handshake, FIFO and GMII signals of the transmit framer bundled as one port.
// The framer uses the slave side; whoever feeds it uses the master side.
interface gmii_tx_framer_if #(parameter int LEN_W = 11);
  logic [7:0]       fifo_data;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [LEN_W-1:0] frame_len;
  logic             frame_req;
  logic             frame_ack;
  logic [7:0]       gmii_tx_data;
  logic             gmii_tx_en;
  logic             gmii_tx_er;
  logic             busy;
  logic             underrun;

  modport master (
    output fifo_data, fifo_empty, frame_len, frame_req,
    input  fifo_rd, frame_ack, gmii_tx_data, gmii_tx_en, gmii_tx_er, busy, underrun
  );
  modport slave (
    input  fifo_data, fifo_empty, frame_len, frame_req,
    output fifo_rd, frame_ack, gmii_tx_data, gmii_tx_en, gmii_tx_er, busy, underrun
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload from a FWFT FIFO, zero pad,
// CRC-32 FCS and inter-frame gap, started by a 4-phase request handshake.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_PAYLOAD  = 60,
  parameter int LEN_W        = 11,
  parameter bit PAD_EN       = 1'b1,
  parameter bit FCS_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  gmii_tx_framer_if.slave bus
);
  localparam int CW = (LEN_W > 8) ? LEN_W : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t           state_q, state_d, tail_state;
  logic [CW-1:0]    cnt_q, cnt_d, tail_cnt;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d, fcs;
  logic [2:0]       sync_q, sync_d;
  logic             frame_ack_q, frame_ack_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rd_c, req_s;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign req_s = sync_q[2];
  assign fcs   = ~crc_q;

  // Stage after the payload is exhausted; also the SFD successor for zero-length frames.
  always_comb begin
    tail_state = S_IFG;
    tail_cnt   = CW'(IFG_LEN - 1);
    if (PAD_EN && (int'(len_q) < MIN_PAYLOAD)) begin
      tail_state = S_PAD;
      tail_cnt   = CW'(MIN_PAYLOAD - 1 - int'(len_q));
    end else if (FCS_EN) begin
      tail_state = S_FCS;
      tail_cnt   = '0;
    end
  end

  // state_q names the byte that goes out on the next edge; outputs are registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    crc_d       = crc_q;
    sync_d      = {sync_q[1:0], bus.frame_req};
    frame_ack_d = frame_ack_q & req_s;
    tx_data_d   = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    underrun_d  = 1'b0;
    rd_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        crc_d = '1;
        if (req_s && !frame_ack_q) begin
          frame_ack_d = 1'b1;
          len_d       = bus.frame_len;
          state_d     = S_PREAMBLE;
          cnt_d       = CW'(PREAMBLE_LEN - 1);
        end
      end
      S_PREAMBLE: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'h55;
        if (cnt_q == '0) state_d = S_SFD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_SFD: begin
        tx_en_d   = 1'b1;
        tx_data_d = 8'hD5;
        if (len_q != '0) begin
          state_d = S_PAYLOAD;
          cnt_d   = CW'(len_q) - CW'(1);
        end else begin
          state_d = tail_state;
          cnt_d   = tail_cnt;
        end
      end
      S_PAYLOAD: begin
        tx_en_d = 1'b1;
        if (bus.fifo_empty) begin
          // Underrun: poison the frame and skip FCS; unread bytes remain queued.
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = S_IFG;
          cnt_d      = CW'(IFG_LEN - 1);
        end else begin
          rd_c      = 1'b1;
          tx_data_d = bus.fifo_data;
          crc_d     = crc_byte(crc_q, bus.fifo_data);
          if (cnt_q == '0) begin
            state_d = tail_state;
            cnt_d   = tail_cnt;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (FCS_EN) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end else begin
          state_d = S_IFG;
          cnt_d   = CW'(IFG_LEN - 1);
        end
      end
      S_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tx_data_d = fcs[7:0];
          2'd1:    tx_data_d = fcs[15:8];
          2'd2:    tx_data_d = fcs[23:16];
          default: tx_data_d = fcs[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          state_d = S_IFG;
          cnt_d   = CW'(IFG_LEN - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IFG: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      crc_q       <= '1;
      sync_q      <= '0;
      frame_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      sync_q      <= sync_d;
      frame_ack_q <= frame_ack_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // The pop strobe is combinational so the FWFT byte is taken in the same cycle.
  assign bus.fifo_rd      = rd_c & ~rst;
  assign bus.frame_ack    = frame_ack_q;
  assign bus.busy         = busy_q;
  assign bus.underrun     = underrun_q;
  assign bus.gmii_tx_en   = tx_en_q;
  assign bus.gmii_tx_er   = tx_er_q;
  assign bus.gmii_tx_data = tx_data_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: default instance for framing/pad/underrun/
// handshake cases, a PAD_EN=0 instance for the "123456789" FCS vector.
module tb_gmii_tx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmii_tx_framer_if #(.LEN_W(11)) ifa ();
  gmii_tx_framer_if #(.LEN_W(11)) ifb ();

  gmii_tx_framer dut_a (.clk(clk), .rst(rst), .bus(ifa));
  gmii_tx_framer #(.PAD_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // FWFT FIFO models; the pop is applied one half-cycle after the consuming edge.
  logic [7:0] fa[$];
  logic [7:0] fb[$];
  logic rda_prev = 1'b0, rdb_prev = 1'b0;
  always @(posedge clk) begin
    rda_prev <= ifa.fifo_rd;
    rdb_prev <= ifb.fifo_rd;
  end
  always @(negedge clk) begin
    if (rda_prev && fa.size() > 0) void'(fa.pop_front());
    if (rdb_prev && fb.size() > 0) void'(fb.pop_front());
    ifa.fifo_empty = (fa.size() == 0);
    ifa.fifo_data  = (fa.size() > 0) ? fa[0] : 8'h00;
    ifb.fifo_empty = (fb.size() == 0);
    ifb.fifo_data  = (fb.size() > 0) ? fb[0] : 8'h00;
  end

  // Line monitors
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int run_a = 0, runlen_a = 0, er_a = 0, und_a = 0, rd_a = 0;
  int idle_a = 0, gap_a = 0, lastgap_a = 0, rises_a = 0, falls_a = 0;
  int run_b = 0, runlen_b = 0;
  bit prev_en_a = 1'b0, cnt_idle_a = 1'b0, prev_en_b = 1'b0;
  always @(negedge clk) begin
    rd_a  <= rd_a + (rda_prev ? 1 : 0);
    und_a <= und_a + (ifa.underrun ? 1 : 0);
    if (ifa.gmii_tx_en) begin
      cap_a.push_back(ifa.gmii_tx_data);
      run_a <= run_a + 1;
      if (ifa.gmii_tx_er) er_a <= er_a + 1;
      if (!prev_en_a) begin
        rises_a   <= rises_a + 1;
        lastgap_a <= gap_a;
      end
    end else if (prev_en_a) begin
      runlen_a   <= run_a;
      run_a      <= 0;
      falls_a    <= falls_a + 1;
      gap_a      <= 1;
      idle_a     <= 1;
      cnt_idle_a <= ifa.busy;
    end else begin
      gap_a <= gap_a + 1;
      if (cnt_idle_a) begin
        idle_a <= idle_a + 1;
        if (!ifa.busy) cnt_idle_a <= 1'b0;
      end
    end
    prev_en_a <= ifa.gmii_tx_en;
    if (ifb.gmii_tx_en) begin
      cap_b.push_back(ifb.gmii_tx_data);
      run_b <= run_b + 1;
    end else if (prev_en_b) begin
      runlen_b <= run_b;
      run_b    <= 0;
    end
    prev_en_b <= ifb.gmii_tx_en;
  end

  logic [7:0] exp_q[$];
  int base, rd0, er0, un0, f0, r0, rd1;

  task automatic build_exp(input int len, input int off, input bit und);
    logic [31:0] c;
    c = '1;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pat(off + i));
      c = crc_upd(c, pat(off + i));
    end
    if (und) exp_q.push_back(8'h00);
    else begin
      for (int i = len; i < 60; i++) begin
        exp_q.push_back(8'h00);
        c = crc_upd(c, 8'h00);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic cmp_frame(input string tag, input int b);
    int nb, n;
    nb = 0;
    n  = cap_a.size() - b;
    chk({tag, "_nbytes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (cap_a[b + i] !== exp_q[i]) nb++;
    chk({tag, "_bytes"}, nb, 0);
  endtask

  task automatic snap();
    base = cap_a.size(); rd0 = rd_a; er0 = er_a; un0 = und_a; f0 = falls_a; r0 = rises_a;
  endtask

  task automatic start_a(input int len, input int off, input int nload);
    for (int i = 0; i < nload; i++) fa.push_back(pat(off + i));
    ifa.frame_len = 11'(len);
    ifa.frame_req = 1'b1;
  endtask

  task automatic wait_ack_a(input string tag);
    int t;
    t = 0;
    while (!ifa.frame_ack && t < 40) begin tick(); t++; end
    chk({tag, "_ack_set"}, ifa.frame_ack, 1);
    ifa.frame_req = 1'b0;
    t = 0;
    while (ifa.frame_ack && t < 40) begin tick(); t++; end
    chk({tag, "_ack_clr"}, ifa.frame_ack, 0);
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int t;
    t = 0;
    while (ifa.busy && t < budget) begin tick(); t++; end
    chk({tag, "_done"}, ifa.busy, 0);
  endtask

  task automatic std_frame(input string tag, input int len);
    snap();
    start_a(len, 0, len);
    wait_ack_a(tag);
    wait_idle_a(tag, len + 300);
    build_exp(len, 0, 1'b0);
    cmp_frame(tag, base);
    chk({tag, "_en_len"}, runlen_a, 8 + ((len < 60) ? 60 : len) + 4);
    chk({tag, "_rd"}, rd_a - rd0, len);
    chk({tag, "_ifg"}, idle_a, 12);
    chk({tag, "_er"}, er_a - er0, 0);
    chk({tag, "_und"}, und_a - un0, 0);
  endtask

  initial begin
    int t;
    string s;
    ifa.frame_req = 1'b0; ifa.frame_len = '0;
    ifb.frame_req = 1'b0; ifb.frame_len = '0;
    repeat (3) tick();
    chk("rst_outs_a", {ifa.gmii_tx_data, ifa.gmii_tx_en, ifa.gmii_tx_er, ifa.frame_ack,
                       ifa.busy, ifa.underrun, ifa.fifo_rd}, 0);
    chk("rst_outs_b", {ifb.gmii_tx_data, ifb.gmii_tx_en, ifb.busy, ifb.frame_ack}, 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_no_start", {ifa.busy, ifa.gmii_tx_en, ifa.frame_ack}, 0);

    std_frame("f64", 64);
    std_frame("pad10", 10);
    std_frame("len0", 0);

    // FIFO holds only 20 of the 64 announced bytes
    snap();
    start_a(64, 0, 20);
    wait_ack_a("undr");
    wait_idle_a("undr", 400);
    build_exp(20, 0, 1'b1);
    cmp_frame("undr", base);
    chk("undr_en_len", runlen_a, 29);
    chk("undr_er", er_a - er0, 1);
    chk("undr_pulse", und_a - un0, 1);
    chk("undr_rd", rd_a - rd0, 20);
    chk("undr_ifg", idle_a, 12);

    std_frame("lenmax", 2047);

    // Request held through a frame, dropped and re-raised inside the gap
    snap();
    start_a(10, 0, 20);
    t = 0;
    while (falls_a == f0 && t < 300) begin tick(); t++; end
    chk("b2b_first_end", falls_a - f0, 1);
    chk("b2b_ack_held", ifa.frame_ack, 1);
    tick();
    ifa.frame_req = 1'b0;
    repeat (4) tick();
    chk("b2b_in_ifg", ifa.busy, 1);
    ifa.frame_req = 1'b1;
    t = 0;
    while (rises_a < r0 + 2 && t < 100) begin tick(); t++; end
    chk("b2b_second_start", rises_a - r0, 2);
    chk("b2b_gap_min", lastgap_a >= 12, 1);
    wait_ack_a("b2b");
    wait_idle_a("b2b", 300);
    build_exp(10, 10, 1'b0);
    cmp_frame("b2b_second", base + 72);
    chk("b2b_rd", rd_a - rd0, 20);

    // Reset in the middle of the payload
    snap();
    start_a(64, 0, 64);
    wait_ack_a("rstmid");
    t = 0;
    while (rd_a - rd0 < 10 && t < 100) begin tick(); t++; end
    chk("rstmid_reached", rd_a - rd0 >= 10, 1);
    rst = 1'b1;
    rd1 = rd_a;
    tick();
    chk("rstmid_outs", {ifa.gmii_tx_data, ifa.gmii_tx_en, ifa.gmii_tx_er, ifa.frame_ack,
                        ifa.busy, ifa.underrun, ifa.fifo_rd}, 0);
    tick();
    rst = 1'b0;
    fa.delete();
    repeat (30) tick();
    chk("rstmid_no_rd", rd_a - rd1, 0);
    chk("rstmid_idle", {ifa.busy, ifa.gmii_tx_en}, 0);

    // PAD_EN=0 instance: CRC-32 check vector
    s = "123456789";
    for (int i = 0; i < 9; i++) fb.push_back(s[i]);
    ifb.frame_len = 11'd9;
    ifb.frame_req = 1'b1;
    t = 0;
    while (!ifb.frame_ack && t < 40) begin tick(); t++; end
    chk("crc_ack_set", ifb.frame_ack, 1);
    ifb.frame_req = 1'b0;
    t = 0;
    while ((ifb.busy || ifb.frame_ack) && t < 200) begin tick(); t++; end
    chk("crc_done", {ifb.busy, ifb.frame_ack}, 0);
    chk("crc_en_len", runlen_b, 21);
    chk("crc_nbytes", cap_b.size(), 21);
    if (cap_b.size() == 21) begin
      chk("crc_payload0", cap_b[8], 8'h31);
      chk("crc_fcs", {cap_b[20], cap_b[19], cap_b[18], cap_b[17]}, 32'hCBF4_3926);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
